// File: rtl/fir_pkg.sv
// Shared FIR constants and the sample type used by the FIR output path.
package fir_pkg;

  localparam int FIR_DATA_W        = 16;
  localparam int FIR_OUT_DEPTH_DEF = 8;

  typedef logic [FIR_DATA_W-1:0] fir_sample_t;

endpackage

// File: rtl/fir_out_mem.sv
// Sample storage for the FIR output FIFO: one write port, asynchronous read.
module fir_out_mem #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  // Contents are left unreset; the buffer masks the read data while empty.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fir_out_buffer.sv
// FIFO between the FIR result port and a ready/valid consumer, with sticky
// overflow/error flags. Define FIR_OUT_PEAK_EN to build the peak tracker.
module fir_out_buffer
  import fir_pkg::*;
#(
  parameter int DEPTH  = FIR_OUT_DEPTH_DEF,
  parameter int DATA_W = FIR_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      fir_data,
  input  logic                   fir_valid,
  input  logic                   fir_error,
  input  logic                   clear,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   err_seen,
  output logic [DATA_W-1:0]      peak
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              r_overflow;
  logic              r_err_seen;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic [DATA_W-1:0] w_rdata;

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LVL_FULL);
  assign w_pop      = !w_empty && out_ready;
  assign w_push_req = fir_valid && !fir_error;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push     = w_push_req && (!w_full || w_pop);

  fir_out_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push && !clear),
    .i_waddr (r_wr_ptr),
    .i_wdata (fir_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_err_seen <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_err_seen <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
      if (fir_error)                      r_err_seen <= 1'b1;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_rdata;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign err_seen  = r_err_seen;

`ifdef FIR_OUT_PEAK_EN
  logic [DATA_W-1:0] r_peak;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_peak <= '0;
    end else if (clear) begin
      r_peak <= '0;
    end else if (w_push && (fir_data > r_peak)) begin
      r_peak <= fir_data;
    end
  end

  assign peak = r_peak;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_fir_out_buffer.sv
// Scoreboard bench for fir_out_buffer: queue-based reference model, directed
// scenarios followed by a randomized phase.
module tb_fir_out_buffer;
  import fir_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  fir_sample_t       fir_data;
  logic              fir_valid;
  logic              fir_error;
  logic              clear;
  fir_sample_t       out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              err_seen;
  fir_sample_t       peak;

  fir_out_buffer #(.DEPTH(DEPTH), .DATA_W(FIR_DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .fir_data  (fir_data),
    .fir_valid (fir_valid),
    .fir_error (fir_error),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .err_seen  (err_seen),
    .peak      (peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state after the most recent modelled edge (m_*) and the state the
  // DUT should currently be showing (s_*).
  fir_sample_t sb_q[$];
  int          m_level = 0, s_level = 0;
  logic        m_ovf = 0, s_ovf = 0;
  logic        m_err = 0, s_err = 0;
  int          m_peak = 0, s_peak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic e, input int d, input logic r, input logic c);
    bit pop, acc;
    @(posedge clk);
    #1;
    fir_valid = v;
    fir_error = e;
    fir_data  = fir_sample_t'(d);
    out_ready = r;
    clear     = c;
    s_level = m_level; s_ovf = m_ovf; s_err = m_err; s_peak = m_peak;
    if (c) begin
      sb_q.delete();
      m_level = 0; m_ovf = 0; m_err = 0; m_peak = 0;
    end else begin
      pop = (m_level > 0) && r;
      acc = v && !e;
      if (e) m_err = 1;
      if (acc && m_level == DEPTH && !pop) begin
        m_ovf = 1;
      end else if (acc) begin
        sb_q.push_back(fir_sample_t'(d));
        m_level++;
`ifdef FIR_OUT_PEAK_EN
        if ((d & 16'hFFFF) > m_peak) m_peak = d & 16'hFFFF;
`endif
      end
      if (pop) m_level--;
    end
  endtask

  task automatic idle(input logic r, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, r, 1'b0);
  endtask

  // Monitor: checks visible state every cycle and pops the scoreboard on
  // each handshake the DUT will honour at the coming edge.
  initial begin
    fir_sample_t exp_d;
    forever begin
      @(negedge clk);
      chk("level", level, s_level);
      chk("out_valid", out_valid, s_level != 0);
      chk("overflow", overflow, s_ovf);
      chk("err_seen", err_seen, s_err);
      chk("peak", peak, s_peak);
      if (s_level == 0) chk("out_data_empty", out_data, 0);
      if (reset && !clear && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          exp_d = sb_q.pop_front();
          chk("out_data", out_data, exp_d);
        end
      end
    end
  end

  initial begin
    int pk_exp;
    reset = 1'b0; fir_valid = 0; fir_error = 0; fir_data = '0; clear = 0; out_ready = 0;
    #23 reset = 1'b1;

    // Back-to-back pushes with a ready consumer stay at level <= 1.
    drive(1, 0, 4, 1, 0);
    drive(1, 0, 5, 1, 0);
    drive(1, 0, 6, 1, 0);
    idle(1, 3);

    // Overfill with consumer stalled.
    for (int i = 1; i <= 9; i++) drive(1, 0, i, 0, 0);
    idle(0, 1);
    @(negedge clk);
    chk("full_level", level, 8);
    chk("full_overflow", overflow, 1);
    idle(1, DEPTH + 2);
    drive(0, 0, 0, 0, 1);
    idle(0, 1);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) drive(1, 0, 101 + i, 0, 0);
    drive(1, 0, 10, 1, 0);
    idle(0, 1);
    @(negedge clk);
    chk("full_pushpop_level", level, 8);
    chk("full_pushpop_overflow", overflow, 0);
    idle(1, DEPTH + 2);

    // Errored results are discarded; clear drops the sticky flag.
    drive(1, 1, 77, 0, 0);
    idle(0, 1);
    @(negedge clk);
    chk("err_level", level, 0);
    chk("err_seen_set", err_seen, 1);
    drive(0, 0, 0, 0, 1);
    idle(0, 1);
    @(negedge clk);
    chk("err_seen_cleared", err_seen, 0);
    drive(0, 1, 0, 0, 0);
    idle(0, 1);
    drive(0, 0, 0, 0, 1);

    // Peak tracking.
    drive(1, 0, 20, 1, 0);
    drive(1, 0, 300, 1, 0);
    drive(1, 0, 7, 1, 0);
    idle(1, 2);
`ifdef FIR_OUT_PEAK_EN
    pk_exp = 300;
`else
    pk_exp = 0;
`endif
    @(negedge clk);
    chk("peak_value", peak, pk_exp);
    drive(0, 0, 0, 0, 1);
    idle(0, 1);
    @(negedge clk);
    chk("peak_cleared", peak, 0);

    // Asynchronous reset in the middle of a burst.
    drive(1, 0, 11, 0, 0);
    drive(1, 0, 12, 0, 0);
    drive(1, 0, 13, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    fir_valid = 0; fir_error = 0; fir_data = '0; clear = 0; out_ready = 0;
    sb_q.delete();
    m_level = 0; m_ovf = 0; m_err = 0; m_peak = 0;
    s_level = 0; s_ovf = 0; s_err = 0; s_peak = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_out_data", out_data, 0);
    #10 reset = 1'b1;
    drive(1, 0, 42, 0, 0);
    idle(0, 1);
    @(negedge clk);
    chk("post_rst_data", out_data, 42);
    idle(1, 2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 65535)),
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 199) == 0);
    end
    idle(1, DEPTH + 2);
    @(negedge clk);
    chk("final_drained", level, 0);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_out_buffer.md
FIR_OUT_BUFFER -- requirements
Module: fir_out_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter DATA_W, default 16, sample width; matches FIR data_out width.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port fir_data  input  DATA_W  FIR result, driven from FIR data_out.
REQ-006 Port fir_valid  input  1  FIR result qualifier, driven from FIR out_enable.
REQ-007 Port fir_error  input  1  FIR error indication, driven from FIR error.
REQ-008 Port clear  input  1  synchronous flush of FIFO and all sticky flags.
REQ-009 Port out_data  output  DATA_W  head-of-FIFO sample.
REQ-010 Port out_valid  output  1  out_data holds a valid sample.
REQ-011 Port out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 Port level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 Port overflow  output  1  sticky: a FIR result was dropped because the FIFO was full.
REQ-014 Port err_seen  output  1  sticky: fir_error was sampled high.
REQ-015 Port peak  output  DATA_W  largest accepted sample (see Configuration).

Function
REQ-016 Push: fir_valid=1 and fir_error=0 at a clock edge writes fir_data at the write pointer, unless the FIFO is full with no pop in that cycle.
REQ-017 Pop: out_valid=1 and out_ready=1 at a clock edge advances the read pointer.
REQ-018 Latency: a sample pushed into an empty FIFO at edge N appears on out_data with out_valid=1 after edge N (one cycle); no combinational path from fir_* to out_*.
REQ-019 out_data is stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous push and pop in the same cycle: both occur, level unchanged; legal even when full or with level=1.
REQ-021 Push when full without pop: sample dropped, FIFO contents and pointers unchanged, overflow set to 1.
REQ-022 Pop when empty: ignored; out_valid=0 when level=0.
REQ-023 Pointers wrap modulo DEPTH; full/empty derived from level, never ambiguous.
REQ-024 fir_valid=1 with fir_error=1: sample discarded, err_seen set; fir_error=1 without fir_valid also sets err_seen.
REQ-025 clear=1: level, pointers, overflow, err_seen, peak return to reset values at next edge; clear has priority over simultaneous push/pop.
REQ-026 Samples are treated as unsigned DATA_W values; no width change, scaling or saturation.

Reset
REQ-027 reset=0 asynchronously forces: level=0, pointers=0, out_valid=0, out_data=0, overflow=0, err_seen=0, peak=0.
REQ-028 Reset asserted mid-stream discards all buffered samples; first push after release lands at entry 0.
REQ-029 Storage array contents need not be reset; out_data reads 0 while empty.

Configuration
REQ-030 Macro FIR_OUT_PEAK_EN defined: peak updates on each accepted push to max(peak, fir_data), cleared by reset/clear.
REQ-031 Macro FIR_OUT_PEAK_EN undefined: peak tied to 0, no comparator or register synthesized; port list identical.

Structure
REQ-032 Package fir_pkg holds FIR_DATA_W=16, FIR_OUT_DEPTH_DEF=8, and the shared sample typedef fir_sample_t.
REQ-033 One sub-module, fir_out_mem: DEPTH x DATA_W register array, one write port, one asynchronous read port; pointer/flag logic stays in fir_out_buffer.

Verification
REQ-034 Reset then push 4,5,6 on consecutive cycles with out_ready=1 -> out_data 4,5,6 on following cycles, level never exceeds 1.
REQ-035 out_ready=0, push 9 samples 1..9 with DEPTH=8 -> level=8, overflow=1, drain yields 1..8 only.
REQ-036 Full FIFO, push 10 with out_ready=1 same cycle -> level stays 8, 10 emerges last, overflow stays 0.
REQ-037 fir_valid=1, fir_error=1, fir_data=77 -> level unchanged, err_seen=1; clear=1 -> err_seen=0.
REQ-038 Push 3 samples, assert reset=0 between edges -> outputs zero immediately; after release push 42 -> out_data=42.
REQ-039 FIR_OUT_PEAK_EN defined, push 20,300,7 -> peak=300; clear -> peak=0; undefined -> peak=0 throughout.
